spi_flash_responder: RTL and testbench

- SPI flash emulator: the responder end of the SPI READ (0x03) protocol used by the boot-time ROM loader.
- Decodes the opcode and 24-bit big-endian address, then streams bytes from a byte-wide memory port MSB-first with auto-increment until chip select deasserts.
- Used as a simulation/FPGA stand-in for the config flash, so the ROM loader can be exercised without a physical flash part.
- Runs in the same clk domain as the initiator. SPI inputs are registered initiator outputs; no synchronizers.

---
 rtl/spi_flash_responder.sv | 125 ++++++++++++
 tb/tb_spi_flash_responder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder.sv
// SPI READ (0x03) responder emulating a config flash for the ROM loader.
// Decodes opcode + 24-bit address, then streams memory bytes MSB-first until cs rises.
`timescale 1ns/1ps
module spi_flash_responder #(
  parameter int unsigned MEM_AW      = 24,
  parameter logic [7:0]  READ_OPCODE = 8'h03
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_cs,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_en,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              bad_cmd,
  output logic [15:0]       bytes_served
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_IGNORE
  } state_t;

  state_t      state, state_next;
  logic        sclk_q;
  logic [4:0]  bit_cnt;
  logic [7:0]  sr;
  logic [23:0] addr;
  logic        rise;
  logic [7:0]  opcode;
  logic [2:0]  bit_idx;

  assign rise    = spi_sclk & ~sclk_q & ~spi_cs;
  assign opcode  = {sr[6:0], spi_mosi};
  assign bit_idx = 3'd7 - bit_cnt[2:0];

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state != S_IDLE && spi_cs) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (!spi_cs) state_next = S_CMD;
        S_CMD:   if (rise && bit_cnt == 5'd7)
                   state_next = (opcode == READ_OPCODE) ? S_ADDR : S_IGNORE;
        S_ADDR:  if (rise && bit_cnt == 5'd23) state_next = S_DATA;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_q       <= 1'b1;
      bit_cnt      <= '0;
      sr           <= '0;
      addr         <= '0;
      bad_cmd      <= 1'b0;
      bytes_served <= '0;
    end else begin
      sclk_q  <= spi_sclk;
      bad_cmd <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!spi_cs) begin
            bit_cnt <= '0;
            sr      <= '0;
          end
        end
        S_CMD: begin
          if (rise) begin
            sr <= opcode;
            if (bit_cnt == 5'd7) begin
              bit_cnt <= '0;
              bad_cmd <= (opcode != READ_OPCODE);
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        S_ADDR: begin
          if (rise) begin
            addr <= {addr[22:0], spi_mosi};
            if (bit_cnt == 5'd23) bit_cnt <= '0;
            else                  bit_cnt <= bit_cnt + 5'd1;
          end
        end
        S_DATA: begin
          // Byte completion advances the address so the next MSB is ready before the next rise.
          if (rise) begin
            if (bit_cnt[2:0] == 3'd7) begin
              bit_cnt      <= '0;
              addr         <= addr + 24'd1;
              bytes_served <= bytes_served + 16'd1;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    spi_miso = 1'b1;
    if (state == S_DATA) spi_miso = mem_rdata[bit_idx];
  end

  assign mem_addr = addr[MEM_AW-1:0];
  assign mem_en   = (state == S_DATA);
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: loader-style initiator with a byte scoreboard.
`timescale 1ns/1ps
module tb_spi_flash_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_cs;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso;
  logic [23:0] mem_addr;
  logic        mem_en;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic        bad_cmd;
  logic [15:0] bytes_served;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  logic [15:0] exp_served;

  logic [7:0]  exp_data_q[$];
  logic [23:0] exp_addr_q[$];

  logic        mon_en = 1'b0;
  int unsigned mon_bad, mon_miso0, mon_memen;

  spi_flash_responder #(
    .MEM_AW(24),
    .READ_OPCODE(8'h03)
  ) dut (
    .clk(clk),
    .reset(reset),
    .spi_cs(spi_cs),
    .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .mem_addr(mem_addr),
    .mem_en(mem_en),
    .mem_rdata(mem_rdata),
    .busy(busy),
    .bad_cmd(bad_cmd),
    .bytes_served(bytes_served)
  );

  always #5 clk = ~clk;

  // Backing memory: byte[a] = a[7:0] ^ 0xA5, asynchronous read.
  assign mem_rdata = mem_addr[7:0] ^ 8'hA5;

  always @(negedge clk) begin
    if (!mon_en) begin
      mon_bad   = 0;
      mon_miso0 = 0;
      mon_memen = 0;
    end else begin
      if (bad_cmd)   mon_bad++;
      if (!spi_miso) mon_miso0++;
      if (mem_en)    mon_memen++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One bit at 1-clk half-period: sample miso/mem_addr while sclk is low, then raise sclk.
  task automatic sclk_bit(input logic mosi_v, output logic miso_v, output logic [23:0] ma);
    @(posedge clk); #1;
    miso_v   = spi_miso;
    ma       = mem_addr;
    spi_sclk = 1'b0;
    spi_mosi = mosi_v;
    @(posedge clk); #1;
    spi_sclk = 1'b1;
  endtask

  task automatic send_bits(input logic [23:0] v, input int unsigned n);
    logic b;
    logic [23:0] ma;
    for (int i = int'(n) - 1; i >= 0; i--) sclk_bit(v[i], b, ma);
  endtask

  task automatic cs_low();
    @(posedge clk); #1;
    spi_cs   = 1'b0;
    spi_sclk = 1'b1;
  endtask

  task automatic recv_bytes(input logic [23:0] start, input int unsigned n);
    logic [23:0] ea;
    logic [23:0] ma, ma0;
    logic [7:0]  rx;
    logic        b;
    ea = start;
    for (int k = 0; k < int'(n); k++) begin
      exp_addr_q.push_back(ea);
      exp_data_q.push_back(ea[7:0] ^ 8'hA5);
      ea = ea + 24'd1;
    end
    for (int k = 0; k < int'(n); k++) begin
      for (int i = 7; i >= 0; i--) begin
        sclk_bit(1'b0, b, ma);
        rx[i] = b;
        if (i == 7) ma0 = ma;
      end
      check("mem_addr", {8'h0, ma0}, {8'h0, exp_addr_q.pop_front()});
      check("rx_byte", {24'h0, rx}, {24'h0, exp_data_q.pop_front()});
    end
  endtask

  task automatic cs_high_check_busy();
    @(posedge clk); #1;
    spi_cs = 1'b1;
    check("busy_before_idle", {31'h0, busy}, 32'h1);
    @(posedge clk); #1;
    check("busy_after_cs", {31'h0, busy}, 32'h0);
  endtask

  task automatic read_txn(input logic [23:0] a, input int unsigned n);
    cs_low();
    send_bits(24'h03, 8);
    send_bits(a, 24);
    recv_bytes(a, n);
    @(posedge clk); #1;
    exp_served = exp_served + 16'(n);
    check("bytes_served", {16'h0, bytes_served}, {16'h0, exp_served});
    check("mem_en_data", {31'h0, mem_en}, 32'h1);
    cs_high_check_busy();
    check("mem_en_idle", {31'h0, mem_en}, 32'h0);
  endtask

  task automatic check_reset_outputs();
    check("rst_miso", {31'h0, spi_miso}, 32'h1);
    check("rst_mem_addr", {8'h0, mem_addr}, 32'h0);
    check("rst_mem_en", {31'h0, mem_en}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_bad_cmd", {31'h0, bad_cmd}, 32'h0);
    check("rst_bytes_served", {16'h0, bytes_served}, 32'h0);
  endtask

  initial begin
    logic        b;
    logic [23:0] ma;
    reset    = 1'b1;
    spi_cs   = 1'b1;
    spi_sclk = 1'b1;
    spi_mosi = 1'b0;
    exp_served = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Loader-style read at 0x100000
    read_txn(24'h100000, 2);

    // Long burst across a byte-address carry
    read_txn(24'h0000FE, 4);

    // 24-bit address wrap
    read_txn(24'hFFFFFF, 2);

    // Bad opcode 0x0B with 4 bytes of trailing clocks
    mon_en = 1'b1;
    cs_low();
    send_bits(24'h0B, 8);
    for (int i = 0; i < 32; i++) sclk_bit(1'($urandom_range(0, 1)), b, ma);
    @(posedge clk); #1;
    check("ignore_busy", {31'h0, busy}, 32'h1);
    spi_cs = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("bad_cmd_pulses", mon_bad, 32'd1);
    check("ignore_miso_low_cycles", mon_miso0, 32'd0);
    check("ignore_mem_en_cycles", mon_memen, 32'd0);
    check("bad_bytes_served", {16'h0, bytes_served}, {16'h0, exp_served});
    check("bad_busy", {31'h0, busy}, 32'h0);
    mon_en = 1'b0;

    // Abort after 10 address bits, then a clean read at 0x000010
    cs_low();
    send_bits(24'h03, 8);
    send_bits(24'h3FF, 10);
    cs_high_check_busy();
    check("abort_bytes_served", {16'h0, bytes_served}, {16'h0, exp_served});
    read_txn(24'h000010, 1);

    // Reset mid-DATA, cs high afterwards
    cs_low();
    send_bits(24'h03, 8);
    send_bits(24'h000040, 24);
    for (int i = 0; i < 3; i++) sclk_bit(1'b0, b, ma);
    @(posedge clk); #1;
    reset  = 1'b1;
    spi_cs = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs();
    reset = 1'b0;
    exp_served = '0;
    @(posedge clk); #1;
    check("post_reset_busy", {31'h0, busy}, 32'h0);
    read_txn(24'h000200, 1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
